mac_vector_sequencer: RTL and testbench

- Initiator/feeder side of the 8x8 saturating MAC accumulator: buffers a stream of operand pairs, issues them one per cycle to the MAC's A/B inputs, and clears the accumulator between vectors.
- Captures the final 16-bit sum and returns it with a valid/ready handshake.
- Sits between an operand producer (memory reader or testbench stream) and one MAC instance; turns the free-running MAC into a dot-product engine.

---
 rtl/mac_vector_sequencer_if.sv | 36 +++
 rtl/mac_vector_sequencer.sv | 155 +++++++++++++++
 tb/tb_mac_vector_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_vector_sequencer_if.sv
// Operand stream, MAC drive and result handshake bundled for the dot-product sequencer.
interface mac_vector_sequencer_if #(
    parameter int unsigned LEN_W = 8
);
    // Operand stream from the producer
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;

    // Drive into and readback from the MAC accumulator
    logic [7:0]       mac_a;
    logic [7:0]       mac_b;
    logic             mac_reset_p;
    logic [15:0]      mac_s;

    // Result handshake to the consumer
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_sum;
    logic [LEN_W-1:0] res_count;
    logic             res_sat;

    // Sequencer side
    modport master (
        input  in_valid, in_a, in_b, in_last, mac_s, res_ready,
        output in_ready, mac_a, mac_b, mac_reset_p, res_valid, res_sum, res_count, res_sat
    );

    // Producer / MAC / consumer side
    modport slave (
        output in_valid, in_a, in_b, in_last, mac_s, res_ready,
        input  in_ready, mac_a, mac_b, mac_reset_p, res_valid, res_sum, res_count, res_sat
    );
endinterface

// File: rtl/mac_vector_sequencer.sv
// Feeds buffered operand pairs into a free-running saturating MAC, one pair per cycle,
// clears it between vectors and returns the final sum over a valid/ready handshake.
module mac_vector_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    mac_vector_sequencer_if.master        bus,
    output logic                          busy
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StRun,
        StDrain,
        StCapt,
        StResult
    } state_e;

    state_e           state;

    logic [7:0]       fifo_a    [FIFO_DEPTH];
    logic [7:0]       fifo_b    [FIFO_DEPTH];
    logic             fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fill;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic [7:0]       issue_a;
    logic [7:0]       issue_b;
    logic             clear_mac;
    logic [LEN_W-1:0] elem_count;
    logic             result_valid;
    logic [15:0]      result_sum;
    logic [LEN_W-1:0] result_count;
    logic             result_sat;

    assign fifo_full  = (fill == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (fill == '0);
    // Ready looks only at the full flag, so a pop at full never makes room the same cycle
    assign bus.in_ready = reset_n && !fifo_full;
    assign push       = bus.in_valid && bus.in_ready;
    assign pop        = (state == StRun) && !fifo_empty;

    // Operand storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_a[wr_ptr]    <= bus.in_a;
            fifo_b[wr_ptr]    <= bus.in_b;
            fifo_last[wr_ptr] <= bus.in_last;
        end
    end

    // FIFO pointers and fill level; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + (PTR_W + 1)'(1);
                2'b01:   fill <= fill - (PTR_W + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Vector sequencing FSM with registered MAC drive and result outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= StIdle;
            issue_a      <= '0;
            issue_b      <= '0;
            clear_mac    <= 1'b1;
            elem_count   <= '0;
            result_valid <= 1'b0;
            result_sum   <= '0;
            result_count <= '0;
            result_sat   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // MAC has no enable: any cycle not issuing a pair adds zero
            issue_a   <= '0;
            issue_b   <= '0;
            clear_mac <= 1'b0;
            case (state)
                StIdle: begin
                    if (!fifo_empty) begin
                        state     <= StClr;
                        clear_mac <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StClr: begin
                    elem_count <= '0;
                    state      <= StRun;
                end
                StRun: begin
                    if (!fifo_empty) begin
                        issue_a <= fifo_a[rd_ptr];
                        issue_b <= fifo_b[rd_ptr];
                        if (elem_count != '1) begin
                            elem_count <= elem_count + LEN_W'(1);
                        end
                        if (fifo_last[rd_ptr]) begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    state <= StCapt;
                end
                StCapt: begin
                    result_sum   <= bus.mac_s;
                    result_sat   <= (bus.mac_s == 16'hFFFF);
                    result_count <= elem_count;
                    result_valid <= 1'b1;
                    state        <= StResult;
                end
                StResult: begin
                    if (bus.res_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.mac_a       = issue_a;
    assign bus.mac_b       = issue_b;
    assign bus.mac_reset_p = clear_mac;
    assign bus.res_valid   = result_valid;
    assign bus.res_sum     = result_sum;
    assign bus.res_count   = result_count;
    assign bus.res_sat     = result_sat;
endmodule

// File: tb/tb_mac_vector_sequencer.sv
// Directed bench for mac_vector_sequencer with a behavioural saturating 8x8 MAC attached.
module tb_mac_vector_sequencer;
    localparam int unsigned LEN_W = 8;

    logic clock = 1'b0;
    logic reset_n;
    logic busy;

    mac_vector_sequencer_if #(.LEN_W(LEN_W)) bus ();

    mac_vector_sequencer #(
        .FIFO_DEPTH (4),
        .LEN_W      (LEN_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    // Behavioural MAC: synchronous clear, otherwise saturating accumulate of a*b
    function automatic logic [15:0] sat_add(input logic [15:0] s, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [16:0] t;
        t = {1'b0, s} + (17'(a) * 17'(b));
        return t[16] ? 16'hFFFF : t[15:0];
    endfunction

    logic [15:0] mac_acc;
    assign bus.mac_s = mac_acc;

    always @(posedge clock) begin
        if (bus.mac_reset_p) mac_acc <= 16'd0;
        else                 mac_acc <= sat_add(mac_acc, bus.mac_a, bus.mac_b);
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Edge bookkeeping: last edge that issued a nonzero pair, edge where res_valid rose
    int   last_issue_cyc = 0;
    int   rv_rise_cyc    = 0;
    int   issue_count    = 0;
    logic rv_prev        = 1'b0;
    always @(posedge clock) begin
        #1;
        if (bus.mac_a != 8'd0 || bus.mac_b != 8'd0) begin
            last_issue_cyc = cyc;
            issue_count    = issue_count + 1;
        end
        if (bus.res_valid && !rv_prev) rv_rise_cyc = cyc;
        rv_prev = bus.res_valid;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Called at a negedge; returns at the negedge after the pair was accepted
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        int t;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check("send_timeout", 32'd0, 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] sum,
                               input logic [LEN_W-1:0] count, input logic sat,
                               input logic handshake);
        int t;
        t = 0;
        while (!bus.res_valid && t < 100) begin
            @(negedge clock);
            t++;
        end
        check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_sum"},   32'(bus.res_sum),   32'(sum));
        check({tag, "_count"}, 32'(bus.res_count), 32'(count));
        check({tag, "_sat"},   32'(bus.res_sat),   32'(sat));
        if (handshake) begin
            bus.res_ready = 1'b1;
            @(negedge clock);
            bus.res_ready = 1'b0;
            check({tag, "_drop"}, 32'(bus.res_valid), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d",
                 n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] va [6];
        logic [7:0] vb [6];
        logic       vl [6];
        int         n0;
        int         p;
        int         t;
        int         accepted;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'd0;
        bus.in_b      = 8'd0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_sum",   32'(bus.res_sum),   32'd0);
        check("rst_res_count", 32'(bus.res_count), 32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_mac_clr",   32'(bus.mac_reset_p), 32'd1);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_mac_a",     32'(bus.mac_a),     32'd0);
        reset_n = 1'b1;
        #1;
        check("rel_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clock);
        check("rel_mac_clr",   32'(bus.mac_reset_p), 32'd0);

        // 3*4 + 5*6 + 7*8 = 98, res_ready held high throughout
        bus.res_ready = 1'b1;
        n0 = issue_count;
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b0);
        send(8'd7, 8'd8, 1'b1);
        wait_result("v1", 16'd98, LEN_W'(3), 1'b0, 1'b1);
        check("v1_latency", 32'(rv_rise_cyc - last_issue_cyc), 32'd2);
        check("v1_issues",  32'(issue_count - n0), 32'd3);

        // Two 255*255 products overflow 16 bits
        send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        wait_result("sat", 16'hFFFF, LEN_W'(2), 1'b1, 1'b1);
        send(8'd1, 8'd1, 1'b1);
        wait_result("clr", 16'd1, LEN_W'(1), 1'b0, 1'b1);

        // Gapped input forces RUN bubbles; bubbles must issue zeros
        n0 = issue_count;
        send(8'd3, 8'd4, 1'b0);
        @(negedge clock);
        send(8'd5, 8'd6, 1'b0);
        @(negedge clock);
        send(8'd7, 8'd8, 1'b1);
        wait_result("gap", 16'd98, LEN_W'(3), 1'b0, 1'b0);
        check("gap_issues", 32'(issue_count - n0), 32'd3);

        // Result held: six pairs offered, only four fit; 1*2+3*4=14, 4+5+9+4=22
        va = '{8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd4};
        vb = '{8'd2, 8'd4, 8'd2, 8'd5, 8'd3, 8'd1};
        vl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = va[i];
            bus.in_b     = vb[i];
            bus.in_last  = vl[i];
            t = 0;
            while (!bus.in_ready && t < 8) begin
                @(negedge clock);
                t++;
            end
            if (!bus.in_ready) break;
            @(negedge clock);
            accepted++;
        end
        bus.in_valid = 1'b0;
        check("full_accepted", 32'(accepted), 32'd4);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("hold_valid",    32'(bus.res_valid), 32'd1);
        check("hold_sum",      32'(bus.res_sum),   32'd98);
        check("hold_count",    32'(bus.res_count), 32'd3);
        bus.res_ready = 1'b1;
        @(negedge clock);
        bus.res_ready = 1'b0;
        for (int i = accepted; i < 6; i++) send(va[i], vb[i], vl[i]);
        wait_result("q1", 16'd14, LEN_W'(2), 1'b0, 1'b1);
        wait_result("q2", 16'd22, LEN_W'(4), 1'b0, 1'b1);

        // Reset mid-RUN after two of three pairs issued
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b0);
        t = 0;
        while (bus.mac_a != 8'd5 && t < 20) begin
            @(negedge clock);
            t++;
        end
        check("mid_second_issue", 32'(bus.mac_a), 32'd5);
        reset_n = 1'b0;
        @(negedge clock);
        check("mid_res_valid", 32'(bus.res_valid), 32'd0);
        check("mid_res_sum",   32'(bus.res_sum),   32'd0);
        check("mid_res_count", 32'(bus.res_count), 32'd0);
        check("mid_res_sat",   32'(bus.res_sat),   32'd0);
        check("mid_busy",      32'(busy),          32'd0);
        check("mid_mac_clr",   32'(bus.mac_reset_p), 32'd1);
        check("mid_mac_a",     32'(bus.mac_a),     32'd0);
        check("mid_in_ready",  32'(bus.in_ready),  32'd0);
        reset_n = 1'b1;
        #1;
        check("mid_rel_ready", 32'(bus.in_ready),  32'd1);
        @(negedge clock);
        check("mid_rel_clr",   32'(bus.mac_reset_p), 32'd0);
        check("mid_rel_busy",  32'(busy),          32'd0);
        send(8'd2, 8'd3, 1'b1);
        p = cyc;
        wait_result("post", 16'd6, LEN_W'(1), 1'b0, 1'b1);
        // IDLE -> CLR -> RUN -> DRAIN -> CAPT -> RESULT after the push edge
        check("post_latency", 32'(rv_rise_cyc - p), 32'd5);

        // Element count saturates at 255, sum does not
        for (int i = 0; i < 300; i++) send(8'd1, 8'd1, (i == 299));
        wait_result("long", 16'd300, LEN_W'(255), 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
